branch_resolve_unit: RTL and testbench

//  Parametrised branch condition resolver with a built-in 2-bit bimodal predictor.

---
 rtl/branch_resolve_unit_pkg.sv | 37 +++
 rtl/branch_resolve_unit_if.sv | 36 +++
 rtl/branch_resolve_unit_cond_eval.sv | 39 +++
 rtl/branch_resolve_unit.sv | 127 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//   br_mode_t    : compare-mode encodings presented on in_mode
//   out_state_t  : EMPTY/FULL occupancy of the result register
//   CNT_INIT     : reset value of every 2-bit predictor counter (weakly not-taken)
//   cnt_update() : saturating 2-bit counter step toward the resolved direction
package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        BR_BEQ    = 3'd0,
        BR_BNE    = 3'd1,
        BR_BLEZ   = 3'd2,
        BR_BGTZ   = 3'd3,
        BR_BLTZ   = 3'd4,
        BR_BGEZ   = 3'd5,
        BR_ALWAYS = 3'd6,
        BR_NEVER  = 3'd7
    } br_mode_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    localparam logic [1:0] CNT_INIT = 2'b01;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result bus of the branch resolve unit.
//   in_*   : branch presented for resolution (valid/ready handshake)
//   out_*  : registered resolution result (valid/ready handshake)
// master : the pipeline side that issues branches and consumes results
// slave  : the resolve unit itself
interface branch_resolve_unit_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 32
);
    import branch_resolve_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    br_mode_t         in_mode;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic [PC_W-1:0]  in_pc;
    logic             in_pred_taken;

    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispredict;
    logic [PC_W-1:0]  out_pc;

    modport master (
        output in_valid, in_mode, in_rs, in_rt, in_pc, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict, out_pc
    );

    modport slave (
        input  in_valid, in_mode, in_rs, in_rt, in_pc, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict, out_pc
    );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// branch_cond_eval: purely combinational branch condition evaluation.
//   mode  : compare mode (br_mode_t)
//   rs    : first operand, signed for the zero-compare modes
//   rt    : second operand, used by BEQ/BNE only
//   taken : resolved direction
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  br_mode_t         mode,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             taken
);

    logic rs_neg;
    logic rs_zero;

    // Zero compares only need the sign bit and a zero detect.
    assign rs_neg  = rs[WIDTH-1];
    assign rs_zero = (rs == '0);

    always_comb begin
        taken = 1'b0;
        case (mode)
            BR_BEQ:    taken = (rs == rt);
            BR_BNE:    taken = (rs != rt);
            BR_BLEZ:   taken = rs_neg | rs_zero;
            BR_BGTZ:   taken = !rs_neg & !rs_zero;
            BR_BLTZ:   taken = rs_neg;
            BR_BGEZ:   taken = !rs_neg;
            BR_ALWAYS: taken = 1'b1;
            BR_NEVER:  taken = 1'b0;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: branch resolver with a 2-bit bimodal predictor.
//   clk, reset_n      : clock, asynchronous active-low reset
//   fetch_pc          : PC looked up in the predictor
//   fetch_pred_taken  : MSB of the addressed counter (combinational)
//   flush             : drop the held result and block acceptance this cycle
//   stat_resolved     : consumed results, saturating
//   stat_mispredict   : consumed mispredicted results, saturating
//   br                : request/result bus (slave side)
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PC_W   = 32,
    parameter int IDX_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PC_W-1:0]       fetch_pc,
    output logic                  fetch_pred_taken,
    input  logic                  flush,
    output logic [STAT_W-1:0]     stat_resolved,
    output logic [STAT_W-1:0]     stat_mispredict,
    branch_resolve_unit_if.slave  br
);

    localparam int DEPTH = 2 ** IDX_W;

    out_state_t       state_reg;
    out_state_t       state_next;
    logic             taken_reg;
    logic             mispredict_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [1:0]       cnt_reg [DEPTH];
    logic [STAT_W-1:0] stat_resolved_reg;
    logic [STAT_W-1:0] stat_mispredict_reg;

    logic             cond_taken;
    logic             out_valid;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] train_idx;
    logic             unused_fetch_bits;

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
        .mode  (br.in_mode),
        .rs    (br.in_rs),
        .rt    (br.in_rt),
        .taken (cond_taken)
    );

    // flush blocks both the accept and the consume of this cycle.
    assign accept  = br.in_valid & in_ready & !flush;
    assign consume = out_valid & br.out_ready & !flush;

    assign lookup_idx = fetch_pc[IDX_W+1:2];
    assign train_idx  = pc_reg[IDX_W+1:2];
    assign unused_fetch_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0]};

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_EMPTY;
        else          state_reg <= state_next;
    end

    // Next-state logic: flush wins, then accept (covers consume+accept), then consume.
    always_comb begin
        state_next = state_reg;
        if (flush)        state_next = ST_EMPTY;
        else if (accept)  state_next = ST_FULL;
        else if (consume) state_next = ST_EMPTY;
    end

    // Output logic.
    always_comb begin
        out_valid = (state_reg == ST_FULL);
        in_ready  = !out_valid | br.out_ready;
    end

    // Result payload only changes on accept, so a held result stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_reg      <= 1'b0;
            mispredict_reg <= 1'b0;
            pc_reg         <= '0;
        end else if (accept) begin
            taken_reg      <= cond_taken;
            mispredict_reg <= cond_taken ^ br.in_pred_taken;
            pc_reg         <= br.in_pc;
        end
    end

    // Predictor table trains from the result being consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_reg[i] <= CNT_INIT;
        end else if (consume) begin
            cnt_reg[train_idx] <= cnt_update(cnt_reg[train_idx], taken_reg);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved_reg   <= '0;
            stat_mispredict_reg <= '0;
        end else if (consume) begin
            if (stat_resolved_reg != '1)
                stat_resolved_reg <= stat_resolved_reg + STAT_W'(1);
            if (mispredict_reg && (stat_mispredict_reg != '1))
                stat_mispredict_reg <= stat_mispredict_reg + STAT_W'(1);
        end
    end

    // Lookup reads the registered table, so a same-cycle train is seen next cycle.
    assign fetch_pred_taken  = cnt_reg[lookup_idx][1];

    assign br.in_ready       = in_ready;
    assign br.out_valid      = out_valid;
    assign br.out_taken      = taken_reg;
    assign br.out_mispredict = mispredict_reg;
    assign br.out_pc         = pc_reg;
    assign stat_resolved     = stat_resolved_reg;
    assign stat_mispredict   = stat_mispredict_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        flush;
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispredict;

    branch_resolve_unit_if #(.WIDTH(32), .PC_W(32)) bif ();

    branch_resolve_unit #(.WIDTH(32), .PC_W(32), .IDX_W(4), .STAT_W(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .flush            (flush),
        .stat_resolved    (stat_resolved),
        .stat_mispredict  (stat_mispredict),
        .br               (bif)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_cnt [16];
    bit          m_valid, m_taken, m_mis;
    logic [31:0] m_pc;
    int          m_sres, m_smis;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_cond(input int mode, input logic [31:0] rs, input logic [31:0] rt);
        int signed a;
        a = signed'(rs);
        case (mode)
            0: return rs == rt;
            1: return rs != rt;
            2: return a <= 0;
            3: return a > 0;
            4: return a < 0;
            5: return a >= 0;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_valid = 0; m_taken = 0; m_mis = 0; m_pc = '0;
        m_sres = 0; m_smis = 0;
    endtask

    task automatic drive(input bit v, input int mode, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc, input bit pred, input bit ordy, input bit fl);
        bif.in_valid      = v;
        bif.in_mode       = br_mode_t'(mode[2:0]);
        bif.in_rs         = rs;
        bif.in_rt         = rt;
        bif.in_pc         = pc;
        bif.in_pred_taken = pred;
        bif.out_ready     = ordy;
        flush             = fl;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit acc, cons, nt;
        int idx;
        #1;
        chk("in_ready", bif.in_ready, !m_valid || bif.out_ready);
        chk("fetch_pred", fetch_pred_taken, m_cnt[fetch_pc[5:2]] >= 2);
        acc  = bif.in_valid && (!m_valid || bif.out_ready) && !flush;
        cons = m_valid && bif.out_ready && !flush;
        if (cons) begin
            idx = m_pc[5:2];
            if (m_taken) m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
            else         m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
            if (m_sres < 65535) m_sres++;
            if (m_mis && m_smis < 65535) m_smis++;
        end
        if (flush) m_valid = 0;
        else if (acc) begin
            nt = ref_cond(int'(bif.in_mode), bif.in_rs, bif.in_rt);
            m_valid = 1; m_taken = nt; m_mis = nt != bif.in_pred_taken; m_pc = bif.in_pc;
        end else if (cons) m_valid = 0;
        @(posedge clk);
        #1;
        chk("out_valid", bif.out_valid, m_valid);
        if (m_valid) begin
            chk("out_taken", bif.out_taken, m_taken);
            chk("out_mispredict", bif.out_mispredict, m_mis);
            chk("out_pc", bif.out_pc, m_pc);
        end
        chk("stat_resolved", stat_resolved, m_sres[15:0]);
        chk("stat_mispredict", stat_mispredict, m_smis[15:0]);
    endtask

    task automatic random_phase(input int n);
        logic [31:0] vals [6];
        logic [31:0] rs, rt;
        vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};
        for (int i = 0; i < n; i++) begin
            rs = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 5)];
            rt = ($urandom_range(0, 1) == 0) ? rs : vals[$urandom_range(0, 5)];
            fetch_pc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), rs, rt,
                  {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            step();
        end
    endtask

    int sres0, smis0;

    initial begin
        reset_n  = 1'b0;
        fetch_pc = 32'h40;
        drive(0, 7, 0, 0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", bif.out_valid, 1'b0);
        chk("reset_out_taken", bif.out_taken, 1'b0);
        chk("reset_out_mis", bif.out_mispredict, 1'b0);
        chk("reset_out_pc", bif.out_pc, 32'h0);
        chk("reset_stat_res", stat_resolved, 16'h0);
        reset_n = 1'b1;

        // 1: signed zero compares
        drive(1, BR_BLEZ, 32'h8000_0000, 0, 32'h44, 1, 1, 0); step();
        chk("t1_blez_neg", bif.out_taken, 1'b1);
        drive(1, BR_BLEZ, 32'h0, 0, 32'h48, 1, 1, 0); step();
        chk("t1_blez_zero", bif.out_taken, 1'b1);
        drive(1, BR_BGTZ, 32'h1, 0, 32'h4C, 1, 1, 0); step();
        chk("t1_bgtz_one", bif.out_taken, 1'b1);
        drive(1, BR_BGEZ, 32'hFFFF_FFFF, 0, 32'h50, 1, 1, 0); step();
        chk("t1_bgez_m1", bif.out_taken, 1'b0);
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        $display("t1 zero-compare sequence done");

        // 2: back-to-back BEQ/BNE
        sres0 = m_sres;
        drive(1, BR_BEQ, 5, 5, 32'h54, 0, 1, 0); step();
        chk("t2_beq", bif.out_taken, 1'b1);
        drive(1, BR_BNE, 5, 5, 32'h58, 0, 1, 0); step();
        chk("t2_bne_valid", bif.out_valid, 1'b1);
        chk("t2_bne", bif.out_taken, 1'b0);
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        chk("t2_stat", stat_resolved, 16'(sres0 + 2));
        $display("t2 back-to-back done");

        // 3: backpressure hold
        drive(1, BR_BEQ, 1, 1, 32'h58, 0, 1, 0); step();
        drive(1, BR_BNE, 1, 2, 32'h5C, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_pc", bif.out_pc, 32'h58);
            chk("t3_in_ready", bif.in_ready, 1'b0);
        end
        bif.out_ready = 1'b1; step();
        chk("t3_release_pc", bif.out_pc, 32'h5C);
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        $display("t3 backpressure done");

        // 4: predictor training at pc 0x40
        fetch_pc = 32'h40;
        smis0 = m_smis;
        for (int k = 0; k < 4; k++) begin
            drive(1, BR_ALWAYS, 0, 0, 32'h40, 0, 1, 0); step();
            if (k == 1) chk("t4_pred_after_first", fetch_pred_taken, 1'b1);
        end
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        chk("t4_stat_mis", stat_mispredict, 16'(smis0 + 4));
        // Counter is saturated at 11: one not-taken leaves it predicting taken.
        drive(1, BR_NEVER, 0, 0, 32'h40, 1, 1, 0); step();
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        chk("t4_saturated", fetch_pred_taken, 1'b1);
        $display("t4 predictor training done");

        // 5: flush on a held result
        sres0 = m_sres;
        drive(1, BR_BEQ, 3, 3, 32'h60, 0, 0, 0); step();
        drive(0, 7, 0, 0, 0, 0, 0, 1); step();
        chk("t5_flush_valid", bif.out_valid, 1'b0);
        chk("t5_flush_stat", stat_resolved, 16'(sres0));
        drive(1, BR_BEQ, 3, 3, 32'h64, 0, 1, 1); step();
        chk("t5_flush_blocks", bif.out_valid, 1'b0);
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        $display("t5 flush done");

        // random traffic against the model
        random_phase(300);
        $display("random phase 1 done");

        // 6: asynchronous reset mid-stream
        drive(1, BR_ALWAYS, 0, 0, 32'h68, 0, 0, 0); step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", bif.out_valid, 1'b0);
        chk("t6_stat_res", stat_resolved, 16'h0);
        chk("t6_stat_mis", stat_mispredict, 16'h0);
        chk("t6_pc", bif.out_pc, 32'h0);
        model_reset();
        drive(0, 7, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i * 4);
            #0.1;
            chk("t6_counter", fetch_pred_taken, 1'b0);
        end
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // One taken consume per entry must flip every counter from 01 to predicting taken.
        for (int i = 0; i < 16; i++) begin
            drive(1, BR_ALWAYS, 0, 0, 32'(i * 4), 1, 1, 0); step();
        end
        drive(0, 7, 0, 0, 0, 0, 1, 0); step();
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i * 4);
            #0.1;
            chk("t6_counter_trained", fetch_pred_taken, 1'b1);
        end
        @(posedge clk);
        #1;
        $display("t6 async reset done");

        random_phase(300);
        $display("random phase 2 done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
